// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan reader: active-low glyph encodings,
// BCD error codes and the frame FSM state type.
package seg_pkg;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_E = 7'b0110000;

    // Alternate renderings some panels use for 6, 9 and 7
    localparam logic [6:0] GLYPH_6_ALT = 7'b1100000;
    localparam logic [6:0] GLYPH_9_ALT = 7'b0001100;
    localparam logic [6:0] GLYPH_7_ALT = 7'b0001101;

    localparam logic [3:0] BCD_ERR = 4'hF;
    localparam logic [3:0] BCD_E   = 4'hE;

    typedef enum logic [1:0] {
        SYNC,
        CAPTURE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low 7-segment pattern to BCD decoder with error flag.
// Define SEG_ALT_GLYPH_EN to also accept the alternate 6/9/7 renderings.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        bcd = BCD_ERR;
        err = 1'b1;
        case (seg_n)
            GLYPH_0: begin bcd = 4'd0; err = 1'b0; end
            GLYPH_1: begin bcd = 4'd1; err = 1'b0; end
            GLYPH_2: begin bcd = 4'd2; err = 1'b0; end
            GLYPH_3: begin bcd = 4'd3; err = 1'b0; end
            GLYPH_4: begin bcd = 4'd4; err = 1'b0; end
            GLYPH_5: begin bcd = 4'd5; err = 1'b0; end
            GLYPH_6: begin bcd = 4'd6; err = 1'b0; end
            GLYPH_7: begin bcd = 4'd7; err = 1'b0; end
            GLYPH_8: begin bcd = 4'd8; err = 1'b0; end
            GLYPH_9: begin bcd = 4'd9; err = 1'b0; end
            GLYPH_E: bcd = BCD_E;
`ifdef SEG_ALT_GLYPH_EN
            GLYPH_6_ALT: begin bcd = 4'd6; err = 1'b0; end
            GLYPH_9_ALT: begin bcd = 4'd9; err = 1'b0; end
            GLYPH_7_ALT: begin bcd = 4'd7; err = 1'b0; end
`else
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reads a multiplexed active-low 7-segment bus, debounces each digit and
// presents one decoded frame on valid/ready. SEG_ALT_GLYPH_EN is honoured by seg_glyph_decode.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    frame_drop
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   next_idx, next_idx_nx, acc_idx, en_idx;
    logic               linger, linger_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [6:0]         prev_seg;
    logic [NUM_DIGITS-1:0] prev_en;
    logic               onehot, same, stable, accept, abort;
    logic [3:0]         dec_bcd;
    logic               dec_err;

    seg_glyph_decode u_decode (
        .seg_n (seg_n),
        .bcd   (dec_bcd),
        .err   (dec_err)
    );

    always_comb begin
        onehot = $onehot(dig_en);
        en_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_en[i]) en_idx = IDX_W'(i);
        end
    end

    // A zero count means no run in progress, so the next valid sample always starts at 1.
    always_comb begin
        same   = (seg_n == prev_seg) && (dig_en == prev_en) && (cnt != '0);
        cnt_nx = '0;
        if (onehot) begin
            if (!same)               cnt_nx = CNT_W'(1);
            else if (cnt == CNT_MAX) cnt_nx = cnt;
            else                     cnt_nx = cnt + CNT_W'(1);
        end
        stable = onehot && (cnt_nx == CNT_MAX);
    end

    // linger: the previous digit is accepted but may still be on the bus; its samples are ignored.
    always_comb begin
        state_nx    = state;
        next_idx_nx = next_idx;
        linger_nx   = linger;
        accept      = 1'b0;
        abort       = 1'b0;
        case (state)
            SYNC: begin
                if (onehot && dig_en[0]) begin
                    state_nx    = CAPTURE;
                    next_idx_nx = '0;
                    linger_nx   = 1'b0;
                    accept      = stable;
                end
            end
            CAPTURE: begin
                if (onehot) begin
                    if (en_idx == next_idx) begin
                        linger_nx = 1'b0;
                        accept    = stable;
                    end else if (!(linger && (en_idx == next_idx - IDX_W'(1)))) begin
                        abort    = 1'b1;
                        state_nx = SYNC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_nx = SYNC;
            end
            default: state_nx = SYNC;
        endcase

        acc_idx = next_idx_nx;
        if (accept) begin
            if (next_idx_nx == LAST_IDX) begin
                state_nx = HOLD;
            end else begin
                next_idx_nx = next_idx_nx + IDX_W'(1);
                linger_nx   = 1'b1;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            next_idx   <= '0;
            linger     <= 1'b0;
            cnt        <= '0;
            prev_seg   <= '1;
            prev_en    <= '0;
            frame_drop <= 1'b0;
            out_bcd    <= '0;
            out_err    <= '0;
        end else begin
            state      <= state_nx;
            next_idx   <= next_idx_nx;
            linger     <= linger_nx;
            cnt        <= cnt_nx;
            prev_seg   <= seg_n;
            prev_en    <= dig_en;
            frame_drop <= abort;
            if (accept) begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if (acc_idx == IDX_W'(d)) begin
                        out_bcd[4*d +: 4] <= dec_bcd;
                        out_err[d]        <= dec_err;
                    end
                end
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Inverse of the team's BCD-to-7-segment decoder.
- Samples a multiplexed, active-low 7-segment display bus (segment pattern plus one-hot digit enable) and debounces each digit's pattern.
- Decodes each pattern back to BCD with a per-digit error flag, then presents one full frame of digits on a valid/ready output.
- Used for display loopback checking and for reading external 7-segment panels.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits per frame (1..8).
- STABLE_CNT, 3, consecutive identical samples required to accept a digit (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high, single clock domain.
- seg_n  in  7  segment lines, active low. Bit 6 = a … bit 0 = g.
- dig_en  in  NUM_DIGITS  digit enable, active high, expected one-hot.
- out_ready  in  1  consumer accepts frame.
- out_valid  out  1  frame available.
- out_bcd  out  4*NUM_DIGITS  decoded digits; digit i at bits [4i+3:4i].
- out_err  out  NUM_DIGITS  per-digit decode error.
- frame_drop  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Glyph decode, active-low a..g:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 0110000 ('E') → 4'hE, err=1.
  - Any other pattern, including blank 1111111 → 4'hF, err=1.
- Sample validity: a cycle is valid only if dig_en is exactly one-hot.
  - Zero-hot or multi-hot clears the stability counter; the sample is ignored.
- Stability counter:
  - Counts consecutive valid cycles with seg_n and dig_en unchanged; saturates at STABLE_CNT.
  - A change in either input reloads the count to 1.
  - The digit is accepted on the cycle the count reaches STABLE_CNT. Its decoded value is registered at the next edge.
- FSM states:
  - SYNC: wait for a valid sample with dig_en[0]=1, then go to CAPTURE with expected index 0.
  - CAPTURE: accept digits in ascending order 0..NUM_DIGITS-1.
    - After digit k is accepted, further samples of digit k are ignored, even if the pattern changes (first stable pattern wins).
    - Next valid enable must be k+1.
    - Abort → SYNC, with frame_drop pulsed for 1 cycle, when any of these occurs:
      - dig_en moves to another index before digit k is accepted;
      - dig_en jumps to an index other than k+1 after acceptance.
    - An invalid (non-one-hot) sample does not abort; it only clears the counter.
    - Accepting digit NUM_DIGITS-1 → HOLD.
  - HOLD: out_valid=1; out_bcd/out_err stable; all inputs ignored. out_valid & out_ready → SYNC on the next edge.
- Latency: out_valid rises on the edge after the STABLE_CNT-th identical sample of the last digit.
- Single-digit build (NUM_DIGITS=1): SYNC→CAPTURE→HOLD without an index check.
- Reset (at any time, including mid-frame or in HOLD):
  - state=SYNC, out_valid=0, out_bcd=0, out_err=0, frame_drop=0, counter=0.
  - Partial frame discarded; no frame_drop pulse.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro SEG_ALT_GLYPH_EN.
- When defined, these alternate glyphs also decode with err=0:
  - 1100000→6 (no top bar);
  - 0001100→9 (no bottom bar);
  - 0001101→7 (with segment f).
- When undefined, these three patterns decode as 4'hF with err=1.

Decomposition:
- Shared package seg_pkg holds:
  - the 7-bit glyph constants (digits 0-9 and 'E', same encodings as the team's encoder);
  - the state enum {SYNC, CAPTURE, HOLD};
  - BCD_ERR=4'hF and BCD_E=4'hE.
- One sub-module, seg_glyph_decode: combinational 7-bit→{4-bit BCD, err}. It honours SEG_ALT_GLYPH_EN and is reusable elsewhere.
- seg_scan_reader holds the FSM, stability counter and frame registers.

Test Plan (NUM_DIGITS=4, STABLE_CNT=3):
- Clean scan: digits 0..3 shown as 1,2,3,4, each held 5 cycles, out_ready=1 → out_valid one cycle; out_bcd=16'h4321, out_err=0.
- Backpressure: as above with out_ready=0 for 20 cycles → out_valid held, out_bcd stable at 16'h4321. A new scan during HOLD is ignored. out_ready=1 → out_valid drops next cycle; state is SYNC.
- Unstable digit: digit 1 held only 2 cycles, then dig_en=4'b0100 → frame_drop pulse, no out_valid. A following clean frame 9,8,7,6 → out_bcd=16'h6789.
- Error glyphs: digit 2 = 0110000, digit 3 = 1111111 → out_bcd=16'hFE21 (digits 0/1 = 1/2), out_err=4'b1100.
- Alt glyph: digit 0 = 1100000 → without macro out_bcd[3:0]=F, err[0]=1; with SEG_ALT_GLYPH_EN, 6 with err[0]=0.
- Reset mid-capture: rst asserted after digit 1 is accepted → all outputs 0, no frame_drop. The next clean frame is captured normally.
